// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - lane encoding shared by the phase lane splitter
package phase_pkg;

    typedef enum logic {
        LANE_V2 = 1'b0,
        LANE_V1 = 1'b1
    } lane_e;

    localparam lane_e START_LANE = LANE_V2;

    function automatic lane_e other_lane(input lane_e lane);
        return (lane == LANE_V2) ? LANE_V1 : LANE_V2;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane FIFO with separate occupancy counter
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    // A full lane refuses a push even while it pops in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/phase_lane_splitter.sv
// rtl/phase_lane_splitter.sv - alternating V2/V1 stream splitter with per-lane FIFOs
module phase_lane_splitter
    import phase_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             v1_valid,
    input  logic             v1_ready,
    output logic [WIDTH-1:0] v1_data,
    output logic             v2_valid,
    input  logic             v2_ready,
    output logic [WIDTH-1:0] v2_data,
    output logic             next_lane,
    output logic [CW-1:0]    v1_count,
    output logic [CW-1:0]    v2_count
);

    lane_e next_lane_q, next_lane_d;
    logic  v1_full, v2_full, v1_empty, v2_empty;
    logic  accept, push_v1, push_v2;

    // Ready looks only at the target lane's registered fullness, never at the consumer readies.
    assign in_ready = !reset && ((next_lane_q == LANE_V1) ? !v1_full : !v2_full);
    assign accept   = in_valid && in_ready;
    assign push_v1  = accept && (next_lane_q == LANE_V1);
    assign push_v2  = accept && (next_lane_q == LANE_V2);

    assign next_lane_d = accept ? other_lane(next_lane_q) : next_lane_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_lane_q <= START_LANE;
        end else begin
            next_lane_q <= next_lane_d;
        end
    end

    assign next_lane = next_lane_q;
    assign v1_valid  = !v1_empty;
    assign v2_valid  = !v2_empty;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_v1_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_v1),
        .push_data_i (in_data),
        .pop_i       (v1_valid && v1_ready),
        .head_data_o (v1_data),
        .count_o     (v1_count),
        .empty_o     (v1_empty),
        .full_o      (v1_full)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_v2_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_v2),
        .push_data_i (in_data),
        .pop_i       (v2_valid && v2_ready),
        .head_data_o (v2_data),
        .count_o     (v2_count),
        .empty_o     (v2_empty),
        .full_o      (v2_full)
    );

endmodule

// File: tb/tb_phase_lane_splitter.sv
// tb/tb_phase_lane_splitter.sv - scoreboard bench for phase_lane_splitter
module tb_phase_lane_splitter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             v1_valid, v1_ready, v2_valid, v2_ready;
    logic [WIDTH-1:0] v1_data, v2_data;
    logic             next_lane;
    logic [CW-1:0]    v1_count, v2_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_v1[$];
    logic [WIDTH-1:0] exp_v2[$];
    bit mdl_lane = 1'b0;

    phase_lane_splitter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .v1_valid  (v1_valid),
        .v1_ready  (v1_ready),
        .v1_data   (v1_data),
        .v2_valid  (v2_valid),
        .v2_ready  (v2_ready),
        .v2_data   (v2_data),
        .next_lane (next_lane),
        .v1_count  (v1_count),
        .v2_count  (v2_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: handshakes are observed mid-cycle and take effect at the next rising edge.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (reset) begin
            exp_v1.delete();
            exp_v2.delete();
            mdl_lane = 1'b0;
        end else begin
            if (v2_valid && v2_ready) begin
                n_cmp++;
                if (exp_v2.size() == 0) begin
                    n_err++;
                    $display("FAIL v2_pop_unexpected: got %h required no word", v2_data);
                end else begin
                    e = exp_v2.pop_front();
                    if (v2_data !== e) begin
                        n_err++;
                        $display("FAIL v2_order: got %h required %h", v2_data, e);
                    end
                end
            end
            if (v1_valid && v1_ready) begin
                n_cmp++;
                if (exp_v1.size() == 0) begin
                    n_err++;
                    $display("FAIL v1_pop_unexpected: got %h required no word", v1_data);
                end else begin
                    e = exp_v1.pop_front();
                    if (v1_data !== e) begin
                        n_err++;
                        $display("FAIL v1_order: got %h required %h", v1_data, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_cmp++;
                if (next_lane !== mdl_lane) begin
                    n_err++;
                    $display("FAIL next_lane_at_accept: got %b required %b", next_lane, mdl_lane);
                end
                if (mdl_lane) exp_v1.push_back(in_data);
                else          exp_v2.push_back(in_data);
                mdl_lane = ~mdl_lane;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        v1_ready = 1'b1;
        v2_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!v1_valid && !v2_valid) break;
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; v1_ready = 1'b0; v2_ready = 1'b0;
        repeat (2) step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_cmp++; if ({v1_valid, v2_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valids: got %b required 00", {v1_valid, v2_valid}); end
        n_cmp++; if (v1_count !== '0 || v2_count !== '0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d required 0/0", v1_count, v2_count); end
        n_cmp++; if (next_lane !== 1'b0) begin n_err++; $display("FAIL reset_next_lane: got %b required 0", next_lane); end
        n_cmp++; if (v1_data !== '0 || v2_data !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h required 00/00", v1_data, v2_data); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_no_backpressure();
        logic [WIDTH-1:0] w;
        v1_ready = 1'b1; v2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'h10 + 8'(i);
            in_valid = 1'b1; in_data = w;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL nobp_in_ready[%0d]: got %b required 1", i, in_ready); end
            step();
            n_cmp++;
            if (i % 2 == 0) begin
                if (v2_valid !== 1'b1 || v2_data !== w) begin n_err++; $display("FAIL nobp_v2_latency[%0d]: got %b/%h required 1/%h", i, v2_valid, v2_data, w); end
            end else begin
                if (v1_valid !== 1'b1 || v1_data !== w) begin n_err++; $display("FAIL nobp_v1_latency[%0d]: got %b/%h required 1/%h", i, v1_valid, v1_data, w); end
            end
        end
        drain();
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL nobp_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    task automatic test_v1_stall();
        v1_ready = 1'b0; v2_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1; in_data = 8'h20 + 8'(k);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept[%0d]: got %b required 1", k, in_ready); end
            step();
        end
        in_data = 8'h29;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_blocked: got %b required 0", in_ready); end
        n_cmp++; if (v1_count !== CW'(DEPTH)) begin n_err++; $display("FAIL stall_v1_count: got %0d required %0d", v1_count, DEPTH); end
        n_cmp++; if (next_lane !== 1'b1) begin n_err++; $display("FAIL stall_next_lane: got %b required 1", next_lane); end
        repeat (3) step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hold: got %b required 0", in_ready); end
        v1_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_no_comb_path: got %b required 0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_reopen: got %b required 1", in_ready); end
        step();
        drain();
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL stall_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc = 0;
        v1_ready = 1'b1;
        while (sent < 6 * DEPTH && cyc < 400) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            v2_ready = 1'($urandom_range(0, 1));
            if (in_ready) sent++;
            step();
            cyc++;
            n_cmp++; if (v2_count > CW'(DEPTH)) begin n_err++; $display("FAIL wrap_v2_bound: got %0d required <= %0d", v2_count, DEPTH); end
        end
        n_cmp++; if (sent != 6 * DEPTH) begin n_err++; $display("FAIL wrap_timeout: got %0d sent required %0d", sent, 6 * DEPTH); end
        drain();
        n_cmp++; if (v2_count !== '0) begin n_err++; $display("FAIL wrap_v2_final: got %0d required 0", v2_count); end
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL wrap_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    task automatic test_simul_push_pop();
        n_cmp++; if (next_lane !== 1'b0) begin n_err++; $display("FAIL pp_start_lane: got %b required 0", next_lane); end
        v1_ready = 1'b1; v2_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'h31 + 8'(k);
            step();
        end
        in_data = 8'h35; v2_ready = 1'b1;
        #1;
        n_cmp++; if (v2_count !== CW'(2) || v2_data !== 8'h31) begin n_err++; $display("FAIL pp_before: got %0d/%h required 2/31", v2_count, v2_data); end
        step();
        n_cmp++; if (v2_count !== CW'(2) || v2_data !== 8'h33) begin n_err++; $display("FAIL pp_after: got %0d/%h required 2/33", v2_count, v2_data); end
        drain();
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL pp_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    task automatic test_reset_mid_burst();
        v1_ready = 1'b0; v2_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(k);
            step();
        end
        n_cmp++; if (v1_count !== CW'(3) || v2_count !== CW'(3)) begin n_err++; $display("FAIL mid_fill: got %0d/%0d required 3/3", v1_count, v2_count); end
        in_data = 8'h46;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({v1_valid, v2_valid, in_ready} !== 3'b000) begin n_err++; $display("FAIL mid_async_valids: got %b required 000", {v1_valid, v2_valid, in_ready}); end
        n_cmp++; if (v1_count !== '0 || v2_count !== '0) begin n_err++; $display("FAIL mid_async_counts: got %0d/%0d required 0/0", v1_count, v2_count); end
        n_cmp++; if (next_lane !== 1'b0) begin n_err++; $display("FAIL mid_async_lane: got %b required 0", next_lane); end
        in_valid = 1'b0; v1_ready = 1'b1; v2_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b required 1", in_ready); end
        step();
        n_cmp++; if (v2_valid !== 1'b1 || v2_data !== 8'hA5 || v1_valid !== 1'b0) begin n_err++; $display("FAIL mid_a5_on_v2: got %b/%h v1=%b required 1/a5 v1=0", v2_valid, v2_data, v1_valid); end
        drain();
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL mid_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    task automatic test_odd_burst();
        reset = 1'b1;
        step();
        reset = 1'b0;
        v1_ready = 1'b1; v2_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (next_lane !== 1'b1) begin n_err++; $display("FAIL odd_idle_lane: got %b required 1", next_lane); end
        in_valid = 1'b1; in_data = 8'h53;
        step();
        n_cmp++; if (v1_valid !== 1'b1 || v1_data !== 8'h53) begin n_err++; $display("FAIL odd_fourth_v1: got %b/%h required 1/53", v1_valid, v1_data); end
        drain();
        n_cmp++; if (exp_v1.size() + exp_v2.size() !== 0) begin n_err++; $display("FAIL odd_drain: got %0d left required 0", exp_v1.size() + exp_v2.size()); end
    endtask

    initial begin
        test_reset();
        test_no_backpressure();
        test_v1_stall();
        test_wrap();
        test_simul_push_pop();
        test_reset_mid_burst();
        test_odd_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/phase_lane_splitter.md
# phase_lane_splitter

Stream splitter that feeds the two-phase clock domain lanes. Accepts one word per `clk` cycle over a valid/ready handshake and deals words strictly alternately to lane V2 and lane V1, starting with V2 after reset. Each lane has its own small FIFO so a stalled lane never reorders or drops data. It sits between the single-rate producer and the two phase-lane consumers, and everything runs on the undivided `clk`.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: per-lane FIFO depth; a power of 2, at least 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  splitter can accept a word this cycle.
- `in_data`  in  WIDTH  producer word.
- `v1_valid`  out  1  lane V1 head word available.
- `v1_ready`  in  1  lane V1 consumer takes the head word.
- `v1_data`  out  WIDTH  lane V1 head word.
- `v2_valid`, `v2_ready`, `v2_data`: same as the V1 signals, for lane V2.
- `next_lane`  out  1  lane the next accepted word goes to; 0 = V2, 1 = V1.
- `v1_count`, `v2_count`  out  $clog2(DEPTH+1)  per-lane occupancy.

## Operation
- **Acceptance:** a word is accepted when `in_valid && in_ready`.
- **Input ready:** `in_ready` = occupancy of lane `next_lane` < DEPTH.
  - It depends on registered state only; there is no combinational path from `v1_ready`/`v2_ready`.
- **Lane selection:** an accepted word is written to the tail of lane `next_lane`, then `next_lane` toggles.
  - `next_lane` never toggles without an acceptance.
  - Strict alternation holds: word k after reset goes to V2 if k is even, V1 if k is odd.
- **Lane output:** `vX_valid` = lane X occupancy != 0. `vX_data` = head entry. A pop occurs on `vX_valid && vX_ready`.
- **Per-lane FIFO:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is separate.
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full, but the push is only offered when count < DEPTH, so a full lane does not accept a push even while it is popping.
- **Blocked lane:** the other lane continues to drain independently. No word is ever skipped to the non-blocked lane.
- **Outputs when a lane is empty:** `vX_data` shows the storage at the read pointer, which is stable but carries no meaning.
- **Reset (asynchronous, including mid-operation):**
  - Both FIFOs are emptied, with pointers and counts set to 0; in-flight words are discarded.
  - `next_lane` = 0 (V2).
  - Storage is cleared to 0.
  - All outputs are 0 during reset: `in_ready` = 0 while `reset` is high, then 1 from the first cycle after release.

## Timing
- **Latency:** a word accepted at edge N is visible on `vX_valid`/`vX_data` after edge N (1 cycle) if that lane was empty. Otherwise it appears behind the older entries.
- **Throughput:** 1 word/cycle total when both lanes drain at least every other cycle.
- **After a pop:** `in_ready` rises in the cycle after a pop frees the target lane (1-cycle bubble, by design).
- **Occupancy outputs:** `vX_count` and `next_lane` update on the same edge as the push/pop that changes them.
- **After reset release:** the first acceptance can occur on the first rising edge after `reset` falls.

## Structure
- **Package `phase_pkg`:** `lane_e` enum (`LANE_V2` = 0, `LANE_V1` = 1) and the post-reset start lane constant `START_LANE` = `LANE_V2`.
- **Sub-module `lane_fifo`** (`WIDTH`, `DEPTH`): push/pop/data/count/empty/full with asynchronous reset. It is instantiated twice.
- **Top level:** `next_lane` register, write steering, `in_ready` mux.

## Test plan
- **Reset release, no backpressure:** drive 0x10..0x17 on consecutive cycles with both ready high.
  - V2 receives 0x10, 0x12, 0x14, 0x16.
  - V1 receives 0x11, 0x13, 0x15, 0x17.
  - Each word arrives 1 cycle after acceptance, and `in_ready` stays 1.
- **V1 stalled (`v1_ready` = 0), DEPTH=4, continuous input:**
  - 8 words are accepted (4 per lane) while V2 drains.
  - The 9th word targets V2 and is accepted; the 10th targets full V1, so `in_ready` = 0.
  - Release `v1_ready`: `in_ready` returns 1 the cycle after the first V1 pop, and order is preserved.
- **Wrap-around:** push and pop 3×DEPTH words through one lane with random ready.
  - Data matches in order.
  - `v2_count` never exceeds DEPTH and reads 0 at the end.
- **Simultaneous push and pop on a lane with count 2:** the count stays 2, and the head advances to the next word.
- **Reset asserted mid-burst with both lanes holding 3 words:**
  - Valid outputs and counts drop to 0 asynchronously, and `next_lane` = 0.
  - After release, the next word (0xA5) appears on V2.
- **Odd-length burst of 3 words, then idle, then 1 word:** the 4th word goes to V1, proving `next_lane` persists across idle cycles.
